// File: rtl/fwd_result_pipe.sv
// Two-slot MEM/WB result pipeline with operand forwarding, load-use pending
// detection and register-file write ports.
module fwd_result_pipe #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned RF_ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     ex0_valid,
  input  logic                     ex0_wen,
  input  logic                     ex0_ld,
  input  logic [RF_ADDR_WIDTH-1:0] ex0_rdaddr,
  input  logic [DATA_WIDTH-1:0]    ex0_data,
  input  logic                     ex1_valid,
  input  logic                     ex1_wen,
  input  logic [RF_ADDR_WIDTH-1:0] ex1_rdaddr,
  input  logic [DATA_WIDTH-1:0]    ex1_data,
  input  logic                     mem_ld_valid,
  input  logic [DATA_WIDTH-1:0]    mem_ld_data,
  input  logic [RF_ADDR_WIDTH-1:0] q_addr [0:3],
  output logic                     q_hit  [0:3],
  output logic [DATA_WIDTH-1:0]    q_data [0:3],
  output logic                     ld_wait,
  output logic                     fwd_stall,
  output logic                     wb0_wen,
  output logic [RF_ADDR_WIDTH-1:0] wb0_addr,
  output logic [DATA_WIDTH-1:0]    wb0_data,
  output logic                     wb1_wen,
  output logic [RF_ADDR_WIDTH-1:0] wb1_addr,
  output logic [DATA_WIDTH-1:0]    wb1_data
);

  localparam int unsigned NQ = 4;

  logic                     mem0_valid, mem0_wen, mem0_ld;
  logic [RF_ADDR_WIDTH-1:0] mem0_addr;
  logic [DATA_WIDTH-1:0]    mem0_data;
  logic                     mem1_valid, mem1_wen;
  logic [RF_ADDR_WIDTH-1:0] mem1_addr;
  logic [DATA_WIDTH-1:0]    mem1_data;
  logic                     wb0_v, wb0_we, wb1_v, wb1_we;
  logic [RF_ADDR_WIDTH-1:0] wb0_a, wb1_a;
  logic [DATA_WIDTH-1:0]    wb0_d, wb1_d;

  logic            hold;
  logic            mem0_live, mem1_live, wb0_live, wb1_live;
  logic [NQ-1:0]   pend;

  assign ld_wait   = mem0_valid & mem0_ld & ~mem_ld_valid;
  assign hold      = stall | ld_wait;
  assign mem0_live = mem0_valid & mem0_wen & (|mem0_addr);
  assign mem1_live = mem1_valid & mem1_wen & (|mem1_addr);
  assign wb0_live  = wb0_v & wb0_we & (|wb0_a);
  assign wb1_live  = wb1_v & wb1_we & (|wb1_a);

  // Stage advance; flush overrides hold and a still-waiting load retires without a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0_valid <= 1'b0;
      mem0_wen   <= 1'b0;
      mem0_ld    <= 1'b0;
      mem0_addr  <= '0;
      mem0_data  <= '0;
      mem1_valid <= 1'b0;
      mem1_wen   <= 1'b0;
      mem1_addr  <= '0;
      mem1_data  <= '0;
      wb0_v      <= 1'b0;
      wb0_we     <= 1'b0;
      wb0_a      <= '0;
      wb0_d      <= '0;
      wb1_v      <= 1'b0;
      wb1_we     <= 1'b0;
      wb1_a      <= '0;
      wb1_d      <= '0;
    end else if (flush || !hold) begin
      wb0_v      <= mem0_valid;
      wb0_we     <= mem0_wen & ~ld_wait;
      wb0_a      <= mem0_addr;
      wb0_d      <= mem0_ld ? mem_ld_data : mem0_data;
      wb1_v      <= mem1_valid;
      wb1_we     <= mem1_wen;
      wb1_a      <= mem1_addr;
      wb1_d      <= mem1_data;
      mem0_valid <= ex0_valid & ~flush;
      mem0_wen   <= ex0_wen;
      mem0_ld    <= ex0_ld & ~flush;
      mem0_addr  <= ex0_rdaddr;
      mem0_data  <= ex0_data;
      mem1_valid <= ex1_valid & ~flush;
      mem1_wen   <= ex1_wen;
      mem1_addr  <= ex1_rdaddr;
      mem1_data  <= ex1_data;
    end
  end

  // Forwarding match, youngest first: MEM1, MEM0, WB1, WB0.
  always_comb begin
    pend = '0;
    for (int k = 0; k < NQ; k++) begin
      q_hit[k]  = 1'b0;
      q_data[k] = '0;
      if (q_addr[k] != '0) begin
        if (mem1_live && mem1_addr == q_addr[k]) begin
          q_hit[k]  = 1'b1;
          q_data[k] = mem1_data;
        end else if (mem0_live && mem0_addr == q_addr[k]) begin
          q_hit[k] = 1'b1;
          if (!mem0_ld)
            q_data[k] = mem0_data;
          else if (mem_ld_valid)
            q_data[k] = mem_ld_data;
          else
            pend[k] = 1'b1;
        end else if (wb1_live && wb1_a == q_addr[k]) begin
          q_hit[k]  = 1'b1;
          q_data[k] = wb1_d;
        end else if (wb0_live && wb0_a == q_addr[k]) begin
          q_hit[k]  = 1'b1;
          q_data[k] = wb0_d;
        end
      end
    end
  end

  assign fwd_stall = |pend;

  assign wb0_wen  = wb0_live & ~hold;
  assign wb0_addr = wb0_a;
  assign wb0_data = wb0_d;
  assign wb1_wen  = wb1_live & ~hold;
  assign wb1_addr = wb1_a;
  assign wb1_data = wb1_d;

endmodule

// File: tb/tb_fwd_result_pipe.sv
// Directed bench for fwd_result_pipe: inline forwarding checks plus a
// writeback scoreboard drained by a negedge monitor.
module tb_fwd_result_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic        ex0_valid, ex0_wen, ex0_ld;
  logic [4:0]  ex0_rdaddr;
  logic [31:0] ex0_data;
  logic        ex1_valid, ex1_wen;
  logic [4:0]  ex1_rdaddr;
  logic [31:0] ex1_data;
  logic        mem_ld_valid;
  logic [31:0] mem_ld_data;
  logic [4:0]  q_addr [0:3];
  logic        q_hit  [0:3];
  logic [31:0] q_data [0:3];
  logic        ld_wait, fwd_stall;
  logic        wb0_wen, wb1_wen;
  logic [4:0]  wb0_addr, wb1_addr;
  logic [31:0] wb0_data, wb1_data;

  int checks = 0;
  int passed = 0;
  logic [36:0] exp0 [$];
  logic [36:0] exp1 [$];

  fwd_result_pipe dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .ex0_valid(ex0_valid), .ex0_wen(ex0_wen), .ex0_ld(ex0_ld),
    .ex0_rdaddr(ex0_rdaddr), .ex0_data(ex0_data),
    .ex1_valid(ex1_valid), .ex1_wen(ex1_wen),
    .ex1_rdaddr(ex1_rdaddr), .ex1_data(ex1_data),
    .mem_ld_valid(mem_ld_valid), .mem_ld_data(mem_ld_data),
    .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data),
    .ld_wait(ld_wait), .fwd_stall(fwd_stall),
    .wb0_wen(wb0_wen), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_wen(wb1_wen), .wb1_addr(wb1_addr), .wb1_data(wb1_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Writeback monitor: each asserted write port must match the oldest expectation.
  always @(negedge clk) begin
    if (wb0_wen) begin
      checks++;
      if (exp0.size() == 0)
        $display("FAIL wb0_unexpected: addr %0d data 0x%0h", wb0_addr, wb0_data);
      else begin
        logic [36:0] e;
        e = exp0.pop_front();
        if ({wb0_addr, wb0_data} === e) passed++;
        else $display("FAIL wb0_write: got 0x%0h expected 0x%0h", {wb0_addr, wb0_data}, e);
      end
    end
    if (wb1_wen) begin
      checks++;
      if (exp1.size() == 0)
        $display("FAIL wb1_unexpected: addr %0d data 0x%0h", wb1_addr, wb1_data);
      else begin
        logic [36:0] e;
        e = exp1.pop_front();
        if ({wb1_addr, wb1_data} === e) passed++;
        else $display("FAIL wb1_write: got 0x%0h expected 0x%0h", {wb1_addr, wb1_data}, e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_ex();
    ex0_valid = 0; ex0_wen = 0; ex0_ld = 0; ex0_rdaddr = 0; ex0_data = 0;
    ex1_valid = 0; ex1_wen = 0; ex1_rdaddr = 0; ex1_data = 0;
  endtask

  task automatic set_ex0(input logic [4:0] a, input logic [31:0] d, input logic ld);
    ex0_valid = 1; ex0_wen = 1; ex0_ld = ld; ex0_rdaddr = a; ex0_data = d;
  endtask

  task automatic set_ex1(input logic [4:0] a, input logic [31:0] d);
    ex1_valid = 1; ex1_wen = 1; ex1_rdaddr = a; ex1_data = d;
  endtask

  initial begin
    rst_n = 0; stall = 0; flush = 0; mem_ld_valid = 0; mem_ld_data = 0;
    clear_ex();
    for (int k = 0; k < 4; k++) q_addr[k] = 0;

    // Reset holds everything inactive even with EX traffic offered
    set_ex0(5'd5, 32'h5, 1'b0);
    q_addr[0] = 5'd5;
    step(); step();
    chk("rst_ld_wait", 64'(ld_wait), 64'd0);
    chk("rst_fwd_stall", 64'(fwd_stall), 64'd0);
    chk("rst_q_hit0", 64'(q_hit[0]), 64'd0);
    chk("rst_wb_wen", 64'({wb0_wen, wb1_wen}), 64'd0);
    clear_ex();
    q_addr[0] = 0;
    rst_n = 1;
    step();

    // Basic forward from MEM then writeback
    set_ex0(5'd5, 32'h11, 1'b0);
    step();
    clear_ex();
    q_addr[2] = 5'd5;
    settle();
    chk("t1_hit", 64'(q_hit[2]), 64'd1);
    chk("t1_data", 64'(q_data[2]), 64'h11);
    exp0.push_back({5'd5, 32'h11});
    step();
    chk("t1_wb0_wen", 64'(wb0_wen), 64'd1);
    chk("t1_wb0_addr", 64'(wb0_addr), 64'd5);
    chk("t1_wb0_data", 64'(wb0_data), 64'h11);
    q_addr[2] = 0;
    step(); step();

    // Priority: MEM1 over MEM0, then MEM over WB
    set_ex0(5'd7, 32'hA, 1'b0);
    set_ex1(5'd7, 32'hB);
    step();
    clear_ex();
    set_ex0(5'd7, 32'hC, 1'b0);
    q_addr[0] = 5'd7;
    settle();
    chk("t2_mem1_hit", 64'(q_hit[0]), 64'd1);
    chk("t2_mem1_data", 64'(q_data[0]), 64'hB);
    exp0.push_back({5'd7, 32'hA});
    exp1.push_back({5'd7, 32'hB});
    step();
    clear_ex();
    settle();
    chk("t2_mem_over_wb", 64'(q_data[0]), 64'hC);
    chk("t2_both_wen", 64'({wb0_wen, wb1_wen}), 64'b11);
    exp0.push_back({5'd7, 32'hC});
    step();
    chk("t2_wb_hit", 64'(q_hit[0]), 64'd1);
    chk("t2_wb_data", 64'(q_data[0]), 64'hC);
    q_addr[0] = 0;
    step(); step();

    // Load waits two cycles for data
    set_ex0(5'd3, 32'hDEAD, 1'b1);
    step();
    clear_ex();
    q_addr[1] = 5'd3;
    settle();
    chk("t3_ld_wait_c1", 64'(ld_wait), 64'd1);
    chk("t3_fwd_stall_c1", 64'(fwd_stall), 64'd1);
    chk("t3_hit_c1", 64'(q_hit[1]), 64'd1);
    step();
    chk("t3_ld_wait_c2", 64'(ld_wait), 64'd1);
    chk("t3_fwd_stall_c2", 64'(fwd_stall), 64'd1);
    step();
    mem_ld_valid = 1; mem_ld_data = 32'h55;
    settle();
    chk("t3_ld_wait_done", 64'(ld_wait), 64'd0);
    chk("t3_fwd_stall_done", 64'(fwd_stall), 64'd0);
    chk("t3_ld_fwd_data", 64'(q_data[1]), 64'h55);
    exp0.push_back({5'd3, 32'h55});
    step();
    mem_ld_valid = 0; mem_ld_data = 0;
    settle();
    chk("t3_wb0_wen", 64'(wb0_wen), 64'd1);
    chk("t3_wb0_data", 64'(wb0_data), 64'h55);
    q_addr[1] = 0;
    step(); step();

    // External stall holds the WB write
    set_ex0(5'd4, 32'h44, 1'b0);
    step();
    clear_ex();
    step();
    stall = 1;
    q_addr[3] = 5'd4;
    settle();
    chk("t4_stall_no_wen", 64'(wb0_wen), 64'd0);
    step();
    chk("t4_stall_hold_wen", 64'(wb0_wen), 64'd0);
    chk("t4_stall_hold_data", 64'(q_data[3]), 64'h44);
    stall = 0;
    exp0.push_back({5'd4, 32'h44});
    settle();
    chk("t4_release_wen", 64'(wb0_wen), 64'd1);
    q_addr[3] = 0;
    step(); step();

    // Address 0 never forwards or writes back
    set_ex0(5'd0, 32'h99, 1'b0);
    step();
    clear_ex();
    settle();
    chk("t5_zero_hit", 64'(q_hit[3]), 64'd0);
    step();
    chk("t5_zero_wen", 64'(wb0_wen), 64'd0);
    step();

    // Flush kills the results being captured
    flush = 1;
    set_ex0(5'd9, 32'h91, 1'b0);
    set_ex1(5'd9, 32'h92);
    step();
    flush = 0;
    clear_ex();
    q_addr[0] = 5'd9;
    settle();
    chk("t6_flush_hit", 64'(q_hit[0]), 64'd0);
    step();
    chk("t6_flush_wen", 64'({wb0_wen, wb1_wen}), 64'd0);
    chk("t6_flush_hit_wb", 64'(q_hit[0]), 64'd0);
    q_addr[0] = 0;
    step();

    // Flush during a waiting load retires it without a write
    set_ex0(5'd6, 32'h0, 1'b1);
    step();
    clear_ex();
    flush = 1;
    settle();
    chk("t7_ld_wait", 64'(ld_wait), 64'd1);
    step();
    flush = 0;
    q_addr[2] = 5'd6;
    settle();
    chk("t7_after_ld_wait", 64'(ld_wait), 64'd0);
    chk("t7_after_hit", 64'(q_hit[2]), 64'd0);
    chk("t7_after_wen", 64'(wb0_wen), 64'd0);
    q_addr[2] = 0;
    step();

    // Flush still lets a completed MEM entry retire
    set_ex0(5'd10, 32'hA0, 1'b0);
    step();
    clear_ex();
    flush = 1;
    exp0.push_back({5'd10, 32'hA0});
    step();
    flush = 0;
    settle();
    chk("t8_flush_retire_wen", 64'(wb0_wen), 64'd1);
    step(); step();

    // Reset while a load is pending
    set_ex0(5'd8, 32'h0, 1'b1);
    step();
    clear_ex();
    q_addr[0] = 5'd8;
    settle();
    chk("t9_pre_ld_wait", 64'(ld_wait), 64'd1);
    rst_n = 0;
    settle();
    chk("t9_rst_ld_wait", 64'(ld_wait), 64'd0);
    chk("t9_rst_fwd_stall", 64'(fwd_stall), 64'd0);
    chk("t9_rst_hit", 64'(q_hit[0]), 64'd0);
    chk("t9_rst_wen", 64'({wb0_wen, wb1_wen}), 64'd0);
    step();
    rst_n = 1;
    step(); step(); step();
    chk("t9_post_hit", 64'(q_hit[0]), 64'd0);
    q_addr[0] = 0;
    step();

    chk("sb_wb0_drained", 64'(exp0.size()), 64'd0);
    chk("sb_wb1_drained", 64'(exp1.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
